// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the FSM state enum, instruction class enum, opcode/op/ALUop/shift
// codes, the decoded-instruction payload and the registered control bundle.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (adds the TRAP state).
package seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned SH_W    = 2;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

  localparam logic [SH_W-1:0] SH_NONE = 2'b00;
  localparam logic [SH_W-1:0] SH_LSL  = 2'b01;
  localparam logic [SH_W-1:0] SH_LSR  = 2'b10;
  localparam logic [SH_W-1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_RD
`ifdef SEQ_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN,
    CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    cls_e               cls;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rm;
    logic [SH_W-1:0]    sh;
    logic [OP_W-1:0]    op;
    logic [INSTR_W-1:0] sximm8;
  } dec_t;

  typedef struct packed {
    logic               w;
    logic               vsel;
    logic               write;
    logic               loada;
    logic               loadb;
    logic               asel;
    logic               bsel;
    logic               loadc;
    logic               loads;
    logic [REG_W-1:0]   writenum;
    logic [REG_W-1:0]   readnum;
    logic [SH_W-1:0]    shift;
    logic [OP_W-1:0]    alu_op;
    logic [INSTR_W-1:0] datapath_in;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{w: 1'b1, default: '0};

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction handshake (in/load/s/w/illegal) plus every
// datapath control the sequencer drives.
// master: instruction source / datapath side; slave: instr_sequencer.
interface instr_sequencer_if;
  import seq_pkg::*;

  logic [INSTR_W-1:0] in;
  logic               load;
  logic               s;
  logic               w;
  logic               illegal;
  logic [INSTR_W-1:0] datapath_in;
  logic               vsel;
  logic               write;
  logic               loada;
  logic               loadb;
  logic               asel;
  logic               bsel;
  logic               loadc;
  logic               loads;
  logic [REG_W-1:0]   writenum;
  logic [REG_W-1:0]   readnum;
  logic [SH_W-1:0]    shift;
  logic [OP_W-1:0]    ALUop;

  modport master (
    output in, load, s,
    input  w, illegal, datapath_in, vsel, write, loada, loadb, asel, bsel,
           loadc, loads, writenum, readnum, shift, ALUop
  );

  modport slave (
    input  in, load, s,
    output w, illegal, datapath_in, vsel, write, loada, loadb, asel, bsel,
           loadc, loads, writenum, readnum, shift, ALUop
  );
endinterface

// File: rtl/instr_sequencer_decoder.sv
// instr_decoder: combinational IR field extraction, sximm8 sign extension
// and instruction classification (including legality).
// Ports: ir_i (instruction word), dec_c_o (decoded payload, combinational).
module instr_decoder
  import seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output dec_t               dec_c_o
);

  logic [OPC_W-1:0] opc;
  logic [OP_W-1:0]  op;

  assign opc = ir_i[15:13];
  assign op  = ir_i[12:11];

  always_comb begin
    dec_c_o        = '0;
    dec_c_o.rn     = ir_i[10:8];
    dec_c_o.rd     = ir_i[7:5];
    dec_c_o.sh     = ir_i[4:3];
    dec_c_o.rm     = ir_i[2:0];
    dec_c_o.op     = op;
    dec_c_o.sximm8 = {{(INSTR_W-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};
    dec_c_o.cls    = CLS_ILLEGAL;
    case (opc)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      dec_c_o.cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) dec_c_o.cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  dec_c_o.cls = CLS_ADD;
          OP_CMP:  dec_c_o.cls = CLS_CMP;
          OP_AND:  dec_c_o.cls = CLS_AND;
          default: dec_c_o.cls = CLS_MVN;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction register + control FSM driving datapath.
// Ports: clk, rst_n (async active-low), bus (instr_sequencer_if.slave).
// Optional macro SEQ_ILLEGAL_TRAP_EN: illegal decode sets sticky `illegal`
// and parks in TRAP until reset; otherwise illegal decode returns to WAIT.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.slave   bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctl_t               ctl_q, ctl_d;
  dec_t               dec;

  // IR only accepts a new word while idle.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && bus.load) ir_d = bus.in;
  end

  // Decoding ir_d (not ir_q) lets outputs be registered against the next
  // state; outside WAIT ir_d equals ir_q, so DECODE sees the held IR.
  instr_decoder u_dec (
    .ir_i    (ir_d),
    .dec_c_o (dec)
  );

  // Next state, then the control word that state will present.
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    ctl_d.shift       = SH_NONE;
    ctl_d.datapath_in = dec.sximm8;

    case (state_q)
      S_WAIT:      if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_MOV_IMM:                  state_d = S_WRITE_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:    state_d = S_GET_A;
          CLS_MOV_REG, CLS_MVN:         state_d = S_GET_B;
`ifdef SEQ_ILLEGAL_TRAP_EN
          default:                      state_d = S_TRAP;
`else
          default:                      state_d = S_WAIT;
`endif
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (dec.cls == CLS_CMP) ? S_WAIT : S_WRITE_RD;
      S_WRITE_RD:  state_d = S_WAIT;
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_WAIT;
    endcase

    case (state_d)
      S_WAIT: ctl_d.w = 1'b1;
      S_WRITE_IMM: begin
        ctl_d.vsel     = 1'b1;
        ctl_d.writenum = dec.rn;
        ctl_d.write    = 1'b1;
      end
      S_GET_A: begin
        ctl_d.readnum = dec.rn;
        ctl_d.loada   = 1'b1;
      end
      S_GET_B: begin
        ctl_d.readnum = dec.rm;
        ctl_d.loadb   = 1'b1;
        ctl_d.shift   = dec.sh;
      end
      S_ALU: begin
        ctl_d.shift  = dec.sh;
        ctl_d.alu_op = dec.op;
        // MOV reg is ADD with the A operand forced to zero.
        ctl_d.asel   = (dec.cls == CLS_MOV_REG);
        if (dec.cls == CLS_CMP) ctl_d.loads = 1'b1;
        else                    ctl_d.loadc = 1'b1;
      end
      S_WRITE_RD: begin
        ctl_d.writenum = dec.rd;
        ctl_d.write    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctl_q   <= CTL_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky: set on the edge that leaves DECODE for TRAP.
  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && dec.cls == CLS_ILLEGAL) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.w           = ctl_q.w;
  assign bus.vsel        = ctl_q.vsel;
  assign bus.write       = ctl_q.write;
  assign bus.loada       = ctl_q.loada;
  assign bus.loadb       = ctl_q.loadb;
  assign bus.asel        = ctl_q.asel;
  assign bus.bsel        = ctl_q.bsel;
  assign bus.loadc       = ctl_q.loadc;
  assign bus.loads       = ctl_q.loads;
  assign bus.writenum    = ctl_q.writenum;
  assign bus.readnum     = ctl_q.readnum;
  assign bus.shift       = ctl_q.shift;
  assign bus.ALUop       = ctl_q.alu_op;
  assign bus.datapath_in = ctl_q.datapath_in;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instructions, a reset
// during GET_B, and randomized instructions, each compared cycle by cycle
// against a per-instruction expected control trace built from the ISA rules.
module tb_instr_sequencer;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic        vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.w = bus.w;         o.illegal = bus.illegal; o.vsel = bus.vsel;
    o.write = bus.write; o.loada = bus.loada;     o.loadb = bus.loadb;
    o.asel = bus.asel;   o.bsel = bus.bsel;       o.loadc = bus.loadc;
    o.loads = bus.loads; o.writenum = bus.writenum; o.readnum = bus.readnum;
    o.shift = bus.shift; o.aluop = bus.ALUop;     o.dp = bus.datapath_in;
    return o;
  endfunction

  // Quiet control word for a given IR: only datapath_in (sximm8) is live.
  function automatic obs_t quiet(input logic [15:0] ir);
    obs_t o = '0;
    o.dp = {{8{ir[7]}}, ir[7:0]};
    return o;
  endfunction

  // Expected per-cycle outputs after the edge that samples s, ending with
  // the first idle cycle (or a run of TRAP cycles).
  function automatic void build_trace(input logic [15:0] ir);
    obs_t q = quiet(ir);
    obs_t t;
    logic [2:0] opc = ir[15:13];
    logic [1:0] op  = ir[12:11];
    bit mov_imm = (opc == 3'd6) && (op == 2'd2);
    bit mov_reg = (opc == 3'd6) && (op == 2'd0);
    bit alu     = (opc == 3'd5);
    bit is_cmp  = alu && (op == 2'd1);
    bit uses_a  = alu && (op != 2'd3);
    exp_q.delete();
    exp_q.push_back(q);
    if (!(mov_imm || mov_reg || alu)) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      t = q; t.illegal = 1'b1;
      repeat (4) exp_q.push_back(t);
      return;
`else
      t = q; t.w = 1'b1; exp_q.push_back(t);
      return;
`endif
    end
    if (mov_imm) begin
      t = q; t.vsel = 1'b1; t.write = 1'b1; t.writenum = ir[10:8];
      exp_q.push_back(t);
    end else begin
      if (uses_a) begin
        t = q; t.readnum = ir[10:8]; t.loada = 1'b1; exp_q.push_back(t);
      end
      t = q; t.readnum = ir[2:0]; t.loadb = 1'b1; t.shift = ir[4:3];
      exp_q.push_back(t);
      t = q; t.shift = ir[4:3]; t.aluop = op; t.asel = mov_reg;
      if (is_cmp) t.loads = 1'b1; else t.loadc = 1'b1;
      exp_q.push_back(t);
      if (!is_cmp) begin
        t = q; t.writenum = ir[7:5]; t.write = 1'b1; exp_q.push_back(t);
      end
    end
    t = q; t.w = 1'b1; exp_q.push_back(t);
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    obs_t r = quiet(16'h0000);
    r.w = 1'b1;
    bus.load = 1'b0; bus.s = 1'b0;
    rst_n = 1'b0;
    #2;
    check("reset", observe(), r);
    rst_n = 1'b1;
    step();
  endtask

  // mode 0: load then s; mode 1: load and s together; mode 2: s only.
  task automatic run_instr(input logic [15:0] ir, input int mode,
                           input bit busy_noise, input string tag);
    obs_t idle;
    build_trace(ir);
    if (mode != 2) begin
      bus.in = ir; bus.load = 1'b1; bus.s = (mode == 1);
      step();
      if (mode == 0) begin
        bus.load = 1'b0;
        idle = quiet(ir); idle.w = 1'b1;
        check({tag, "_loaded"}, observe(), idle);
        bus.s = 1'b1;
        step();
      end
    end else begin
      bus.s = 1'b1;
      step();
    end
    bus.s = 1'b0; bus.load = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s_c%0d", tag, k + 1), observe(), exp_q[k]);
      if (k < exp_q.size() - 1) begin
        if (busy_noise) begin
          bus.load = 1'b1;
          bus.in   = 16'($urandom);
          bus.s    = 1'($urandom);
        end
        step();
      end
    end
    bus.s = 1'b0; bus.load = 1'b0;
    if (exp_q[exp_q.size() - 1].w !== 1'b1) do_reset();
  endtask

  initial begin
    obs_t t;
    logic [4:0]  tbl [6];
    logic [15:0] ir;
    tbl = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    rst_n = 1'b0; bus.in = '0; bus.load = 1'b0; bus.s = 1'b0;
    #12;
    t = quiet(16'h0000); t.w = 1'b1;
    check("por", observe(), t);
    rst_n = 1'b1;
    step();

    run_instr(16'hD007, 0, 1'b0, "mov_r0_7");
    run_instr(16'hD3FB, 1, 1'b0, "mov_r3_m5");
    run_instr(16'hA148, 0, 1'b0, "add_lsl");
    run_instr(16'hA900, 0, 1'b1, "cmp_busyload");
    run_instr(16'hC0B1, 1, 1'b0, "mov_reg");
    run_instr(16'hB8E2, 0, 1'b1, "mvn");
    run_instr(16'hB4A3, 0, 1'b0, "and");
    run_instr(16'h0000, 0, 1'b1, "illegal0");

    // Reset while GET_B is active for ADD R2,R1,R0,LSL#1.
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    step();
    bus.load = 1'b0; bus.s = 1'b0;
    step();
    step();
    t = quiet(16'hA148); t.readnum = 3'd0; t.loadb = 1'b1; t.shift = 2'b01;
    check("getb_before_rst", observe(), t);
    rst_n = 1'b0;
    #1;
    t = quiet(16'h0000); t.w = 1'b1;
    check("rst_mid_getb", observe(), t);
    #2;
    rst_n = 1'b1;
    step();
    run_instr(16'h0000, 2, 1'b0, "post_rst_ir0");

    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ir[15:11] = tbl[$urandom_range(0, 5)];
      run_instr(ir, int'($urandom_range(0, 1)), 1'($urandom),
                $sformatf("rnd%0d_%h", n, ir));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
